// File: rtl/sync_reg_rx.sv
// sync_reg_rx: receive endpoint for NCH asynchronous req/data channels; synchronises each request,
// captures its data, returns an ack level and serialises words onto a round-robin valid/ready port.
module sync_reg_rx #(
  parameter int NCH = 4,
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MODE = 0,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_in,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic [NCH-1:0]       ack_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_chan,
  output logic [WIDTH-1:0]     out_data,
  output logic [NCH-1:0]       overrun,
  input  logic                 clr_overrun
);
  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [IW-1:0] INIT_END = IW'(SYNC_STAGES);
  localparam logic [IW-1:0] INIT_DONE = IW'(SYNC_STAGES + 1);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sync_d [SYNC_STAGES];
  logic [NCH-1:0]   prev_q, prev_d, event_q, event_d, pending_q, pending_d;
  logic [NCH-1:0]   ack_q, ack_d, overrun_q, overrun_d;
  logic [WIDTH-1:0] holding_q [NCH];
  logic [WIDTH-1:0] holding_d [NCH];
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_chan_q, out_chan_d, last_grant_q, last_grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    init_q, init_d;
  logic [NCH-1:0]   sync_last, capture, gnt_oh;
  logic [CW-1:0]    gnt;
  logic             gnt_vld, load, in_init;
  int               idx;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // round-robin search starting just after the last granted channel
  always_comb begin
    gnt_vld = 1'b0;
    gnt = last_grant_q;
    idx = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_vld && pending_q[idx[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    sync_d[0] = req_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    in_init = init_q != INIT_DONE;
    init_d = in_init ? init_q + 1'b1 : init_q;
    prev_d = sync_last;
    event_d = in_init ? '0 : ((MODE == 1) ? (sync_last ^ prev_q) : (sync_last & ~prev_q));
    capture = event_q & ~pending_q;
    load = ~out_valid_q | out_ready;
    gnt_oh = (gnt_vld && load) ? (NCH'(1) << gnt) : '0;
    pending_d = (pending_q | capture) & ~gnt_oh;
    overrun_d = (clr_overrun ? '0 : overrun_q) | (event_q & pending_q);
    for (int i = 0; i < NCH; i++) holding_d[i] = capture[i] ? data_in[i*WIDTH +: WIDTH] : holding_q[i];
    out_valid_d = load ? gnt_vld : out_valid_q;
    out_chan_d = (gnt_vld && load) ? gnt : out_chan_q;
    out_data_d = (gnt_vld && load) ? holding_q[gnt] : out_data_q;
    last_grant_d = (gnt_vld && load) ? gnt : last_grant_q;
    // toggle mode adopts the sender's leftover level at the end of the init window
    ack_d = (MODE == 1) ? ((init_q == INIT_END) ? sync_last : ((ack_q & ~gnt_oh) | (sync_last & gnt_oh)))
                        : ((ack_q & sync_last) | gnt_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
      prev_q <= '0;
      event_q <= '0;
      pending_q <= '0;
      holding_q <= '{default: '0};
      ack_q <= '0;
      overrun_q <= '0;
      out_valid_q <= 1'b0;
      out_chan_q <= '0;
      out_data_q <= '0;
      last_grant_q <= CW'(NCH - 1);
      init_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      event_q <= event_d;
      pending_q <= pending_d;
      holding_q <= holding_d;
      ack_q <= ack_d;
      overrun_q <= overrun_d;
      out_valid_q <= out_valid_d;
      out_chan_q <= out_chan_d;
      out_data_q <= out_data_d;
      last_grant_q <= last_grant_d;
      init_q <= init_d;
    end
  end

  assign ack_out = ack_q;
  assign out_valid = out_valid_q;
  assign out_chan = out_chan_q;
  assign out_data = out_data_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_sync_reg_rx.sv
// tb_sync_reg_rx: scoreboard bench driving a 4-phase (inst 0) and a 2-phase (inst 1) sync_reg_rx
// with directed and randomized sender traffic; per-channel word order is checked by a monitor.
module tb_sync_reg_rx;
  localparam int NCH = 4, W = 32, SS = 2;
  typedef struct { int inst; int ch; logic [W-1:0] data; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, clr_ov = 1'b0;
  logic [NCH-1:0] req [2];
  logic [NCH-1:0] ack [2];
  logic [NCH-1:0] ovr [2];
  logic [NCH*W-1:0] din [2];
  logic rdy [2];
  logic vld [2];
  logic [1:0] och [2];
  logic [W-1:0] odat [2];
  logic [W-1:0] d1;
  exp_t sbq [$];
  int vectors = 0, miscompares = 0;
  bit done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sync_reg_rx #(.NCH(NCH), .WIDTH(W), .SYNC_STAGES(SS), .MODE(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_in(req[g]), .data_in(din[g]), .ack_out(ack[g]),
      .out_valid(vld[g]), .out_ready(rdy[g]), .out_chan(och[g]), .out_data(odat[g]),
      .overrun(ovr[g]), .clr_overrun(clr_ov));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int m, input int c, input logic [W-1:0] d);
    din[m][c*W +: W] = d;
    req[m][c] = (m == 1) ? ~req[m][c] : 1'b1;
    sbq.push_back('{m, c, d});
  endtask

  task automatic wait_ack(input int m, input int c, input logic lvl);
    int n = 0;
    while (ack[m][c] !== lvl && n < 500) begin tick(); n++; end
    vectors++;
    if (ack[m][c] !== lvl) begin
      miscompares++;
      $display("FAIL ack_wait inst%0d ch%0d: got %b expected %b after %0d cycles", m, c, ack[m][c], lvl, n);
    end
  endtask

  task automatic wait_valid(input int m);
    int n = 0;
    while (vld[m] !== 1'b1 && n < 100) begin tick(); n++; end
    vectors++;
    if (vld[m] !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_wait inst%0d: got %b expected 1 after %0d cycles", m, vld[m], n);
    end
  endtask

  task automatic monitor();
    int f;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (rst_n && vld[m] && rdy[m]) begin
          f = -1;
          foreach (sbq[k]) if (f < 0 && sbq[k].inst == m && sbq[k].ch == int'(och[m])) f = k;
          if (f < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_word inst%0d ch%0d: got %0h expected no word", m, och[m], odat[m]);
          end else begin
            chk($sformatf("out_word inst%0d ch%0d", m, och[m]), odat[m], sbq[f].data);
            sbq.delete(f);
          end
        end
      end
    end
  endtask

  task automatic sender(input int m, input int c);
    repeat (12) begin
      tick($urandom_range(1, 6));
      issue(m, c, $urandom);
      wait_ack(m, c, (m == 1) ? req[m][c] : 1'b1);
      if (m == 0) begin
        req[m][c] = 1'b0;
        wait_ack(m, c, 1'b0);
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = '0;
      din[m] = '0;
      rdy[m] = 1'b1;
    end
    fork monitor(); join_none
    tick(3);
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", W'(vld[m]), 0);
      chk("rst_ack", W'(ack[m]), 0);
      chk("rst_overrun", W'(ovr[m]), 0);
      chk("rst_data", odat[m], 0);
      chk("rst_chan", W'(och[m]), 0);
    end
    rst_n = 1'b1;
    tick(SS + 4);
    // simultaneous requests, two rounds, ch0 first each time
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++) issue(0, c, W'(32'h10 + r * 16 + c));
      wait_valid(0);
      for (int c = 0; c < NCH; c++) begin
        chk("rr_valid", W'(vld[0]), 1);
        chk("rr_chan", W'(och[0]), W'(c));
        tick();
      end
      for (int c = 0; c < NCH; c++) wait_ack(0, c, 1'b1);
      req[0] = '0;
      for (int c = 0; c < NCH; c++) wait_ack(0, c, 1'b0);
    end
    // single-word latency and 4-phase ack release
    issue(0, 0, 32'hDEADBEEF);
    tick(4);
    chk("lat_early_valid", W'(vld[0]), 0);
    tick();
    chk("lat_valid", W'(vld[0]), 1);
    chk("lat_chan", W'(och[0]), 0);
    chk("lat_data", odat[0], 32'hDEADBEEF);
    chk("lat_ack", W'(ack[0][0]), 1);
    req[0][0] = 1'b0;
    tick(2);
    chk("ack_hold", W'(ack[0][0]), 1);
    tick();
    chk("ack_fall", W'(ack[0][0]), 0);
    // backpressure
    rdy[0] = 1'b0;
    d1 = $urandom;
    issue(0, 1, d1);
    issue(0, 2, $urandom);
    tick(6);
    for (int k = 0; k < 20; k++) begin
      chk("bp_chan", W'(och[0]), 1);
      chk("bp_data", odat[0], d1);
      chk("bp_ack2", W'(ack[0][2]), 0);
      tick();
    end
    rdy[0] = 1'b1;
    tick();
    chk("bp_next_chan", W'(och[0]), 2);
    chk("bp_next_ack2", W'(ack[0][2]), 1);
    req[0] = '0;
    wait_ack(0, 1, 1'b0);
    wait_ack(0, 2, 1'b0);
    // overrun: sender re-requests while its previous word still waits in the holding reg
    rdy[0] = 1'b0;
    issue(0, 0, 32'h1111AAAA);
    wait_ack(0, 0, 1'b1);
    req[0][0] = 1'b0;
    wait_ack(0, 0, 1'b0);
    issue(0, 0, 32'h2222BBBB);
    tick(8);
    chk("ov_before", W'(ovr[0][0]), 0);
    req[0][0] = 1'b0;
    tick(4);
    din[0][W-1:0] = 32'h3333CCCC;
    req[0][0] = 1'b1;
    tick(8);
    chk("ov_set", W'(ovr[0][0]), 1);
    rdy[0] = 1'b1;
    wait_ack(0, 0, 1'b1);
    tick(2);
    chk("ov_sticky", W'(ovr[0][0]), 1);
    clr_ov = 1'b1;
    tick();
    clr_ov = 1'b0;
    chk("ov_clr", W'(ovr[0][0]), 0);
    req[0][0] = 1'b0;
    wait_ack(0, 0, 1'b0);
    // 2-phase toggles on ch3
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, 3, req[1][3]);
      issue(1, 3, W'(32'hA + k));
    end
    wait_ack(1, 3, req[1][3]);
    chk("tog_ack", W'(ack[1]), 32'h8);
    // randomized traffic on every channel of both instances
    done = 1'b0;
    fork
      begin
        fork
          sender(0, 0); sender(0, 1); sender(0, 2); sender(0, 3);
          sender(1, 0); sender(1, 1); sender(1, 2); sender(1, 3);
        join
        done = 1'b1;
      end
      while (!done) begin
        tick();
        rdy[0] = $urandom_range(0, 3) != 0;
        rdy[1] = $urandom_range(0, 1) == 1;
      end
    join
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    tick(30);
    chk("sb_drained", W'(sbq.size()), 0);
    chk("rand_ovr0", W'(ovr[0]), 0);
    chk("rand_ovr1", W'(ovr[1]), 0);
    // reset mid-burst, then toggle levels held across reset
    for (int c = 0; c < NCH; c++) issue(0, c, $urandom);
    wait_valid(0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", W'(vld[0]), 0);
    chk("rst_mid_ack0", W'(ack[0]), 0);
    chk("rst_mid_ack1", W'(ack[1]), 0);
    sbq.delete();
    req[0] = '0;
    req[1] = 4'b1010;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("init_ack_early", W'(ack[1]), 0);
    tick();
    chk("init_ack", W'(ack[1]), 32'hA);
    for (int k = 0; k < 10; k++) begin
      chk("init_quiet", W'(vld[1]), 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
